// File: rtl/dht11_poll_ctrl_if.sv
// Reader-side bus between the DHT11 poll controller (master) and the one-wire reader (slave).
interface dht11_poll_ctrl_if;
  // Handshake: the master holds rd_measure high until it samples rd_done=1; the slave then
  // keeps rd_done high with stable data bytes until rd_measure has dropped. rd_reset aborts
  // any transfer in progress and the slave must drop rd_done while it is asserted.
  logic       rd_measure;
  logic       rd_reset;
  logic       rd_done;
  logic [7:0] rd_hum;
  logic [7:0] rd_humd;
  logic [7:0] rd_tem;
  logic [7:0] rd_temd;
  logic [7:0] rd_sum;

  modport master (
    output rd_measure, rd_reset,
    input  rd_done, rd_hum, rd_humd, rd_tem, rd_temd, rd_sum
  );

  modport slave (
    input  rd_measure, rd_reset,
    output rd_done, rd_hum, rd_humd, rd_tem, rd_temd, rd_sum
  );
endinterface

// File: rtl/dht11_poll_ctrl.sv
// DHT11 poll scheduler: periodic/forced measurement, timeout and checksum supervision,
// reader reset with bounded retries, and publication of the last good sample.
module dht11_poll_ctrl #(
  parameter int PERIOD_US    = 2000000,
  parameter int TIMEOUT_US   = 50000,
  parameter int RETRY_GAP_US = 1000000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                force_req,
  dht11_poll_ctrl_if.master   rd,
  output logic [7:0]          hum,
  output logic [7:0]          tem,
  output logic                data_valid,
  output logic                sample_stb,
  output logic                busy,
  output logic                fail,
  output logic [7:0]          err_cnt,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_MEASURE     = 3'd1,
    S_CHECK       = 3'd2,
    S_RELEASE     = 3'd3,
    S_FAIL        = 3'd4,
    S_RETRY_WAIT  = 3'd5,
    S_WAIT_PERIOD = 3'd6
  } state_t;

  // One shared timer serves MEASURE, FAIL and RETRY_WAIT; it is sized for the longest of them.
  localparam int TMAX = (TIMEOUT_US > RETRY_GAP_US) ? TIMEOUT_US : RETRY_GAP_US;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int PW   = $clog2(PERIOD_US) + 1;

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_US - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(RETRY_GAP_US - 1);
  localparam logic [PW-1:0] P_LAST    = PW'(PERIOD_US - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  state_t        state;
  logic [TW-1:0] timer;
  logic [PW-1:0] ptimer;
  logic [1:0]    retry;
  logic [7:0]    sum_calc;

  assign sum_calc  = rd.rd_hum + rd.rd_humd + rd.rd_tem + rd.rd_temd;
  assign busy      = (state != S_IDLE) && (state != S_WAIT_PERIOD);
  assign state_dbg = state;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      ptimer        <= '0;
      retry         <= '0;
      rd.rd_measure <= 1'b0;
      rd.rd_reset   <= 1'b0;
      hum           <= '0;
      tem           <= '0;
      data_valid    <= 1'b0;
      sample_stb    <= 1'b0;
      fail          <= 1'b0;
      err_cnt       <= '0;
    end else begin
      sample_stb <= 1'b0;
      // Period timer free-runs from the last restart point and parks at its terminal count.
      if (ptimer != P_LAST) ptimer <= ptimer + PW'(1);

      case (state)
        S_IDLE: begin
          if (enable || force_req) begin
            state         <= S_MEASURE;
            rd.rd_measure <= 1'b1;
            timer         <= '0;
            ptimer        <= '0;
          end
        end

        S_MEASURE: begin
          if (rd.rd_done) begin
            state         <= S_CHECK;
            rd.rd_measure <= 1'b0;
          end else if (timer == TO_LAST) begin
            state         <= S_FAIL;
            rd.rd_measure <= 1'b0;
            rd.rd_reset   <= 1'b1;
            timer         <= '0;
            err_cnt       <= sat_inc(err_cnt);
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_CHECK: begin
          if (rd.rd_sum == sum_calc) begin
            state      <= S_RELEASE;
            hum        <= rd.rd_hum;
            tem        <= rd.rd_tem;
            sample_stb <= 1'b1;
            data_valid <= 1'b1;
            fail       <= 1'b0;
            retry      <= '0;
          end else begin
            state       <= S_FAIL;
            rd.rd_reset <= 1'b1;
            timer       <= '0;
            err_cnt     <= sat_inc(err_cnt);
          end
        end

        S_RELEASE: begin
          if (!rd.rd_done) state <= S_WAIT_PERIOD;
        end

        // rd_reset was raised on entry and stays up for exactly two cycles here.
        S_FAIL: begin
          if (timer == TW'(1)) begin
            state       <= S_RETRY_WAIT;
            rd.rd_reset <= 1'b0;
            timer       <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_RETRY_WAIT: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (retry < RETRY_MAX) begin
              retry         <= retry + 2'd1;
              state         <= S_MEASURE;
              rd.rd_measure <= 1'b1;
              ptimer        <= '0;
            end else begin
              fail   <= 1'b1;
              retry  <= '0;
              state  <= S_WAIT_PERIOD;
              ptimer <= '0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_WAIT_PERIOD: begin
          if (force_req || (enable && ptimer == P_LAST)) begin
            state         <= S_MEASURE;
            rd.rd_measure <= 1'b1;
            timer         <= '0;
            ptimer        <= '0;
          end else if (!enable) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
